// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-port register file with per-register pending (scoreboard)
//            bits. Optional write-to-read bypass with macro REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 32,
    parameter  int NRD    = 2,
    parameter  int NWR    = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NWR-1:0]                wen,
    input  logic [NWR-1:0][AW-1:0]        wsel,
    input  logic [NWR-1:0][DATA_W-1:0]    wdat,
    input  logic [NRD-1:0][AW-1:0]        rsel,
    output logic [NRD-1:0][DATA_W-1:0]    rdat,
    output logic [NRD-1:0]                rbusy,
    input  logic                          rsv_en,
    input  logic [AW-1:0]                 rsv_sel,
    output logic                          rsv_ok,
    input  logic                          flush,
    output logic [AW:0]                   busy_cnt
);

    logic [DATA_W-1:0] r_mem [NREGS];
    logic [NREGS-1:0]  r_pend;
    logic [AW:0]       r_busy_cnt;

    logic [NREGS-1:0]  w_wr_hit;
    logic [NREGS-1:0]  w_pend_nxt;
    logic [AW:0]       w_cnt_nxt;
    logic              w_rsv_ok;

    always_comb begin
        w_wr_hit = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wen[i]) begin
                w_wr_hit[wsel[i]] = 1'b1;
            end
        end
    end

    // A write landing in the same cycle frees the register, so it may be re-reserved.
    assign w_rsv_ok = !RST && rsv_en && (rsv_sel != '0) && !flush &&
                      (!r_pend[rsv_sel] || w_wr_hit[rsv_sel]);
    assign rsv_ok   = w_rsv_ok;

    always_comb begin
        w_pend_nxt = r_pend & ~w_wr_hit;
        if (w_rsv_ok) begin
            w_pend_nxt[rsv_sel] = 1'b1;
        end
        if (flush) begin
            w_pend_nxt = '0;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_pend_nxt[r]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend     <= '0;
            r_busy_cnt <= '0;
            for (int r = 0; r < NREGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            r_pend     <= w_pend_nxt;
            r_busy_cnt <= w_cnt_nxt;
            // Ascending loop: the highest-numbered port's assignment lands last.
            for (int i = 0; i < NWR; i++) begin
                if (wen[i] && (wsel[i] != '0)) begin
                    r_mem[wsel[i]] <= wdat[i];
                end
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

    always_comb begin
        rdat  = '0;
        rbusy = '0;
        for (int j = 0; j < NRD; j++) begin
            rdat[j]  = r_mem[rsel[j]];
            rbusy[j] = r_pend[rsel[j]];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NWR; i++) begin
                if (wen[i] && (wsel[i] == rsel[j]) && (rsel[j] != '0)) begin
                    rdat[j]  = wdat[i];
                    rbusy[j] = 1'b0;
                end
            end
`endif
            if (RST) begin
                rdat[j]  = '0;
                rbusy[j] = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Self-checking bench for regfile_scoreboard: directed scenarios
//            plus randomized traffic compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int NRD    = 2;
    localparam int NWR    = 2;
    localparam int AW     = $clog2(NREGS);

    logic                       CLK;
    logic                       RST;
    logic [NWR-1:0]             wen;
    logic [NWR-1:0][AW-1:0]     wsel;
    logic [NWR-1:0][DATA_W-1:0] wdat;
    logic [NRD-1:0][AW-1:0]     rsel;
    logic [NRD-1:0][DATA_W-1:0] rdat;
    logic [NRD-1:0]             rbusy;
    logic                       rsv_en;
    logic [AW-1:0]              rsv_sel;
    logic                       rsv_ok;
    logic                       flush;
    logic [AW:0]                busy_cnt;

    regfile_scoreboard #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .wen      (wen),
        .wsel     (wsel),
        .wdat     (wdat),
        .rsel     (rsel),
        .rdat     (rdat),
        .rbusy    (rbusy),
        .rsv_en   (rsv_en),
        .rsv_sel  (rsv_sel),
        .rsv_ok   (rsv_ok),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model: register contents and the set of pending registers.
    logic [DATA_W-1:0] m_mem  [NREGS];
    bit                m_pend [NREGS];

    initial begin
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r]  = '0;
            m_pend[r] = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit written_now(input int r);
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && int'(wsel[i]) == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_rsv_ok();
        if (RST || !rsv_en || flush || rsv_sel == '0) return 1'b0;
        return !m_pend[rsv_sel] || written_now(int'(rsv_sel));
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int r = 0; r < NREGS; r++) c += int'(m_pend[r]);
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] exp_rdat(input int j);
        logic [DATA_W-1:0] v;
        if (RST) return '0;
        v = m_mem[rsel[j]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && wsel[i] == rsel[j] && rsel[j] != '0) v = wdat[i];
        end
`endif
        return v;
    endfunction

    function automatic bit exp_rbusy(input int j);
        if (RST) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rsel[j] != '0 && written_now(int'(rsel[j]))) return 1'b0;
`endif
        return m_pend[rsel[j]];
    endfunction

    // Model state advance on each rising edge.
    always @(posedge CLK) begin
        bit ok;
        ok = exp_rsv_ok();
        if (RST) begin
            for (int r = 0; r < NREGS; r++) begin
                m_mem[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wen[i] && wsel[i] != '0) m_mem[wsel[i]] = wdat[i];
            end
            for (int i = 0; i < NWR; i++) begin
                if (wen[i]) m_pend[wsel[i]] = 1'b0;
            end
            if (ok) m_pend[rsv_sel] = 1'b1;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) m_pend[r] = 1'b0;
            end
        end
    end

    // Compare process: inputs change at the falling edge, outputs checked 2 ns later.
    always begin
        @(negedge CLK);
        #2;
        if (chk_en) begin
            for (int j = 0; j < NRD; j++) begin
                chk($sformatf("rdat[%0d]", j), 64'(rdat[j]), 64'(exp_rdat(j)));
                chk($sformatf("rbusy[%0d]", j), 64'(rbusy[j]), 64'(exp_rbusy(j)));
            end
            chk("rsv_ok", 64'(rsv_ok), 64'(exp_rsv_ok()));
            chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
        end
    end

    task automatic nxt();
        @(negedge CLK);
        RST    = 1'b0;
        wen    = '0;
        rsv_en = 1'b0;
        flush  = 1'b0;
    endtask

    initial begin
        RST = 1'b1; wen = '0; wsel = '0; wdat = '0; rsel = '0;
        rsv_en = 1'b1; rsv_sel = AW'(3); flush = 1'b0;
        #3;
        chk("rsv_ok_in_reset", 64'(rsv_ok), 64'(0));
        @(posedge CLK);

        // Post-reset state
        nxt(); chk_en = 1'b1;
        rsel[0] = AW'(0); rsel[1] = AW'(5);
        #3;
        chk("rst_rdat0", 64'(rdat[0]), 64'(0));
        chk("rst_rdat1", 64'(rdat[1]), 64'(0));
        chk("rst_rbusy", 64'(rbusy), 64'(0));
        chk("rst_busy_cnt", 64'(busy_cnt), 64'(0));

        // Same-address write collision, then write to register 0
        nxt(); wen = 2'b11; wsel[0] = AW'(7); wsel[1] = AW'(7);
        wdat[0] = 32'h11; wdat[1] = 32'h22;
        nxt(); rsel[0] = AW'(7);
        wen = 2'b01; wsel[0] = AW'(0); wdat[0] = 32'hFFFF;
        #3; chk("coll_rdat7", 64'(rdat[0]), 64'h22);
        nxt(); rsel[1] = AW'(0);
        #3; chk("reg0_reads0", 64'(rdat[1]), 64'(0));

        // Reserve, duplicate reserve, release by write
        nxt(); rsv_en = 1'b1; rsv_sel = AW'(3);
        #3; chk("rsv3_ok", 64'(rsv_ok), 64'(1));
        nxt(); rsel[0] = AW'(3); rsv_en = 1'b1; rsv_sel = AW'(3);
        #3;
        chk("rsv3_rbusy", 64'(rbusy[0]), 64'(1));
        chk("rsv3_cnt", 64'(busy_cnt), 64'(1));
        chk("rsv3_again", 64'(rsv_ok), 64'(0));
        nxt(); wen = 2'b01; wsel[0] = AW'(3); wdat[0] = 32'hAB;
        nxt(); #3;
        chk("rel3_rbusy", 64'(rbusy[0]), 64'(0));
        chk("rel3_cnt", 64'(busy_cnt), 64'(0));
        chk("rel3_rdat", 64'(rdat[0]), 64'hAB);

        // Write and re-reserve the same pending register in one cycle
        nxt(); rsv_en = 1'b1; rsv_sel = AW'(4);
        nxt(); wen = 2'b10; wsel[1] = AW'(4); wdat[1] = 32'h44;
        rsv_en = 1'b1; rsv_sel = AW'(4);
        #3; chk("wr_rsv4_ok", 64'(rsv_ok), 64'(1));
        nxt(); rsel[0] = AW'(4);
        #3;
        chk("wr_rsv4_rbusy", 64'(rbusy[0]), 64'(1));
        chk("wr_rsv4_cnt", 64'(busy_cnt), 64'(1));
        nxt(); wen = 2'b01; wsel[0] = AW'(4); wdat[0] = 32'h45;

        // Flush beats a simultaneous reservation
        for (int r = 1; r <= 3; r++) begin
            nxt(); rsv_en = 1'b1; rsv_sel = AW'(r);
        end
        nxt(); #3; chk("pre_flush_cnt", 64'(busy_cnt), 64'(3));
        nxt(); flush = 1'b1; rsv_en = 1'b1; rsv_sel = AW'(9);
        #3; chk("flush_rsv_ok", 64'(rsv_ok), 64'(0));
        nxt(); rsel[0] = AW'(9); rsel[1] = AW'(3);
        #3;
        chk("flush_cnt", 64'(busy_cnt), 64'(0));
        chk("flush_rbusy9", 64'(rbusy[0]), 64'(0));
        chk("flush_rbusy3", 64'(rbusy[1]), 64'(0));
        chk("flush_data3", 64'(rdat[1]), 64'hAB);

        // Same-cycle write/read of register 6
        nxt(); wen = 2'b01; wsel[0] = AW'(6); wdat[0] = 32'h55; rsel[0] = AW'(6);
        #3;
`ifdef REGFILE_BYPASS_EN
        chk("byp6_same", 64'(rdat[0]), 64'h55);
`else
        chk("byp6_same", 64'(rdat[0]), 64'(0));
`endif
        nxt(); #3; chk("byp6_next", 64'(rdat[0]), 64'h55);

        // Randomized traffic, biased to low registers to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            nxt();
            RST   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            wen   = NWR'($urandom);
            for (int i = 0; i < NWR; i++) begin
                wsel[i] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wdat[i] = $urandom;
            end
            for (int j = 0; j < NRD; j++) begin
                rsel[j] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            end
            rsv_en  = $urandom_range(0, 1);
            rsv_sel = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
        end

        nxt();
        @(negedge CLK);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have port CLK, input, 1, single clock, all state on rising edge.
REQ-006 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port wen, input, NWR, per-port write enable.
REQ-008 SHALL have port wsel, input, NWR x AW, per-port write address.
REQ-009 SHALL have port wdat, input, NWR x DATA_W, per-port write data.
REQ-010 SHALL have port rsel, input, NRD x AW, per-port read address.
REQ-011 SHALL have port rdat, output, NRD x DATA_W, per-port read data.
REQ-012 SHALL have port rbusy, output, NRD, per-port flag: addressed register has a pending writer.
REQ-013 SHALL have port rsv_en, input, 1, reserve request (mark register pending).
REQ-014 SHALL have port rsv_sel, input, AW, register to reserve.
REQ-015 SHALL have port rsv_ok, output, 1, reservation accepted this cycle (combinational).
REQ-016 SHALL have port flush, input, 1, clear all pending marks.
REQ-017 SHALL have port busy_cnt, output, AW+1, number of registers currently pending.

Function
REQ-018 SHALL hold register 0 at zero; writes to it discarded; never pending; rdat reads 0; rbusy is 0.
REQ-019 SHALL perform writes on the rising edge when wen[i]=1; visible on rdat one cycle later (without bypass).
REQ-020 SHALL resolve same-address simultaneous writes with port NWR-1 winning.
REQ-021 SHALL read combinationally: rdat[j] = register[rsel[j]], rbusy[j] = pending[rsel[j]].
REQ-022 SHALL set rsv_ok=1 when rsv_en=1, rsv_sel!=0, pending[rsv_sel]=0 (or cleared by a write this cycle), and flush=0; otherwise 0.
REQ-023 SHALL set pending[rsv_sel] on the edge when rsv_ok=1.
REQ-024 SHALL clear pending[wsel[i]] on the edge when wen[i]=1, unless the same register is reserved in that cycle (reserve wins).
REQ-025 SHALL clear all pending bits on the edge when flush=1, ignoring rsv_en that cycle; register data unaffected; writes still performed.
REQ-026 SHALL maintain busy_cnt as a registered counter equal to popcount(pending) after every edge (net +1/-k per cycle, saturation impossible, range 0..NREGS-1).
REQ-027 SHALL ignore writes to a non-pending register for pending/busy_cnt purposes (data still written).

Reset
REQ-028 SHALL, on the edge with RST=1, zero all registers, all pending bits and busy_cnt; RST overrides wen, rsv_en, flush in that cycle.
REQ-029 SHALL drive rdat=0, rbusy=0, rsv_ok=0 during and immediately after reset (until written or reserved).

Configuration
REQ-030 SHALL compile write-to-read bypass when macro REGFILE_BYPASS_EN is defined: rdat[j] returns wdat[i] combinationally when wen[i]=1, wsel[i]=rsel[j]!=0 (highest-numbered port wins), and rbusy[j] reads 0 for that port.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return only stored register contents and stored pending state (new data and cleared pending seen next cycle).

Verification
REQ-032 SHALL cover: RST=1 one cycle, then rsel={0,5} -> rdat={0,0}, rbusy=0, busy_cnt=0.
REQ-033 SHALL cover: wen={1,1}, wsel={7,7}, wdat={0x11,0x22} -> next cycle rdat for reg 7 = 0x22; write reg 0 with 0xFFFF -> reads 0.
REQ-034 SHALL cover: rsv reg 3 -> rsv_ok=1, next cycle rbusy=1, busy_cnt=1; rsv reg 3 again -> rsv_ok=0; wen reg 3 0xAB -> next cycle rbusy=0, busy_cnt=0, rdat=0xAB.
REQ-035 SHALL cover: same cycle write reg 4 and reserve reg 4 while pending -> rsv_ok=1, pending stays 1, busy_cnt unchanged.
REQ-036 SHALL cover: reserve regs 1,2,3 then flush with rsv_en on reg 9 -> busy_cnt=0, reg 9 not pending, data intact.
REQ-037 SHALL cover with REGFILE_BYPASS_EN: wen reg 6 0x55 and rsel=6 same cycle -> rdat=0x55 that cycle; without macro -> old value that cycle, 0x55 next.
